// File: rtl/tl_xbar_pkg.sv
// tl_xbar_pkg: types and constants shared by the TileLink crossbar blocks.
// Holds the demux input FSM state enum and the depth of the decoupling FIFO.
// No ports; import with tl_xbar_pkg::*.
package tl_xbar_pkg;

  // Input-side FSM of tl_demux_burst: waiting for a first beat, or locked
  // onto a multi-beat message.
  typedef enum logic [0:0] {
    DMX_IDLE  = 1'b0,
    DMX_BURST = 1'b1
  } dmx_state_e;

  // Entries in the skid FIFO between source and sinks.
  localparam int FIFO_DEPTH = 2;

  // Width of a counter able to hold 0..FIFO_DEPTH.
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/tl_skid_fifo.sv
// tl_skid_fifo: 2-entry width-parametrised valid/ready FIFO with registered outputs.
// Latency: a word pushed at edge t is visible on pop_valid/pop_data after edge t.
// Backpressure: push_ready = (count < 2), taken only from registered state.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   push_valid/ready/data   write side
//   pop_valid/ready/data    read side; pop_data is the head entry, held until popped
module tl_skid_fifo
  import tl_xbar_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  // slot0 is always the head; slot1 is only meaningful when cnt == 2.
  logic [W-1:0]          slot0;
  logic [W-1:0]          slot1;
  logic [FIFO_CNT_W-1:0] cnt;
  logic                  push;
  logic                  pop;

  assign push_ready = (cnt < FIFO_CNT_W'(FIFO_DEPTH));
  assign pop_valid  = (cnt != '0);
  assign pop_data   = slot0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) slot0 <= push_data;
          else           slot1 <= push_data;
          cnt <= cnt + FIFO_CNT_W'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          cnt   <= cnt - FIFO_CNT_W'(1);
        end
        2'b11: begin
          // push_ready excludes cnt == 2, so cnt is 1 here and the new
          // word becomes the head straight away.
          slot0 <= push_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tl_demux_burst.sv
// tl_demux_burst: registered, burst-aware 1-to-N demux; route locked for a whole message.
// Latency: beat accepted at edge t is on valid_o/data_o after edge t; no valid_i/data_i->output path.
// Backpressure: ready_o = FIFO not full for in-range traffic; out-of-range stalls unless error sink.
//
// Build option: define TL_DEMUX_ERR_SINK_EN to accept and drop out-of-range messages
// (err_o pulses once per dropped message); otherwise such traffic stalls and err_o = 0.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i/ready_o/data_i, sel_i, beats_i   source beat; sel_i/beats_i used on first beat only
//   valid_o[N], ready_i[N], data_o[N*DATA_W]  sinks; data_o is the FIFO head on every lane
//   busy_o         high while a multi-beat message is locked
//   err_o          one-cycle pulse when a message is dropped
module tl_demux_burst
  import tl_xbar_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 64,
  parameter int SEL_W  = 2,
  parameter int BEAT_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [BEAT_W-1:0]   beats_i,
  output logic [N-1:0]        valid_o,
  input  logic [N-1:0]        ready_i,
  output logic [N*DATA_W-1:0] data_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int SW1 = SEL_W + 1;
  // N widened by one bit so the range test also works when N == 2^SEL_W.
  localparam logic [SEL_W:0] N_EXT = SW1'(N);

  dmx_state_e        state_q;
  dmx_state_e        state_d;
  logic [SEL_W-1:0]  sel_q;
  logic [BEAT_W-1:0] rem_q;

  logic [SEL_W-1:0]  eff_sel;
  logic              in_range;
  logic              accept;
  logic              fifo_ready;
  logic              head_vld;
  logic              head_pop;
  logic [SEL_W-1:0]  head_sel;
  logic [DATA_W-1:0] head_dat;

  // Route source: the first beat carries its own select, later beats reuse the locked one.
  assign eff_sel  = (state_q == DMX_BURST) ? sel_q : sel_i;
  assign in_range = ({1'b0, eff_sel} < N_EXT);
  assign accept   = valid_i && ready_o;
  assign busy_o   = (state_q == DMX_BURST);

`ifdef TL_DEMUX_ERR_SINK_EN
  logic err_q;

  // Out-of-range beats are swallowed regardless of FIFO fill.
  assign ready_o = !rst_i && (!in_range || fifo_ready);
  assign err_o   = err_q;

  // Only the first beat of a dropped message raises err_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= accept && !in_range && (state_q == DMX_IDLE);
  end
`else
  assign ready_o = !rst_i && in_range && fifo_ready;
  assign err_o   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= DMX_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a single-beat message never leaves IDLE; a burst ends
  // on the beat accepted with one beat remaining.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DMX_IDLE:  if (accept && (beats_i != '0))      state_d = DMX_BURST;
      DMX_BURST: if (accept && (rem_q == BEAT_W'(1))) state_d = DMX_IDLE;
      default:   state_d = DMX_IDLE;
    endcase
  end

  // Locked select and remaining-beat counter. rem_q is never decremented
  // below 1 because the burst closes on that beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q <= '0;
      rem_q <= '0;
    end else if (accept) begin
      if (state_q == DMX_IDLE) begin
        sel_q <= sel_i;
        rem_q <= beats_i;
      end else begin
        rem_q <= rem_q - BEAT_W'(1);
      end
    end
  end

  tl_skid_fifo #(
    .W(SEL_W + DATA_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_valid (accept && in_range),
    .push_ready (fifo_ready),
    .push_data  ({eff_sel, data_i}),
    .pop_valid  (head_vld),
    .pop_ready  (head_pop),
    .pop_data   ({head_sel, head_dat})
  );

  // One-hot decode of the head's destination.
  always_comb begin
    valid_o = '0;
    for (int k = 0; k < N; k++) begin
      if (head_vld && (head_sel == SEL_W'(k))) valid_o[k] = 1'b1;
    end
  end

  // Only the addressed sink's ready matters since valid_o is one-hot.
  assign head_pop = |(valid_o & ready_i);
  assign data_o   = {N{head_dat}};

endmodule

// File: tb/tb_tl_demux_burst.sv
`timescale 1ns/1ps
module tb_tl_demux_burst;
  localparam int N      = 4;
  localparam int DATA_W = 64;
  localparam int SEL_W  = 2;
  localparam int BEAT_W = 4;
  localparam int NB     = 3;
`ifdef TL_DEMUX_ERR_SINK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                valid_i = 1'b0;
  logic                ready_o;
  logic [DATA_W-1:0]   data_i  = '0;
  logic [SEL_W-1:0]    sel_i   = '0;
  logic [BEAT_W-1:0]   beats_i = '0;
  logic [N-1:0]        valid_o;
  logic [N-1:0]        ready_i = '1;
  logic [N*DATA_W-1:0] data_o;
  logic                busy_o, err_o;

  logic                 b_valid = 1'b0;
  logic                 b_ready_o;
  logic [DATA_W-1:0]    b_data  = '0;
  logic [SEL_W-1:0]     b_sel   = '0;
  logic [BEAT_W-1:0]    b_beats = '0;
  logic [NB-1:0]        b_valid_o;
  logic [NB-1:0]        b_ready = '1;
  logic [NB*DATA_W-1:0] b_data_o;
  logic                 b_busy_o, b_err_o;

  tl_demux_burst #(.N(N), .DATA_W(DATA_W), .SEL_W(SEL_W), .BEAT_W(BEAT_W)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .sel_i(sel_i), .beats_i(beats_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .busy_o(busy_o), .err_o(err_o));

  tl_demux_burst #(.N(NB), .DATA_W(DATA_W), .SEL_W(SEL_W), .BEAT_W(BEAT_W)) dut_b (
    .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .ready_o(b_ready_o), .data_i(b_data),
    .sel_i(b_sel), .beats_i(b_beats), .valid_o(b_valid_o), .ready_i(b_ready),
    .data_o(b_data_o), .busy_o(b_busy_o), .err_o(b_err_o));

  int checks = 0;
  int failures = 0;

  // Reference model: messages are counted by beats left; every routed beat
  // waits in one in-order queue whose size is the buffer occupancy.
  typedef struct {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } beat_t;
  beat_t            exp_q[$];
  int               mdl_left = 0;
  logic [SEL_W-1:0] mdl_dest = '0;
  int               delivered = 0;
  bit               rand_rdy = 1'b0;

  logic [SEL_W-1:0] m_sel;
  logic             m_rdy;
  logic [N-1:0]     m_vld;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ({valid_o, busy_o, err_o, ready_o} !== '0) begin
        failures++;
        $display("FAIL reset_outputs valid=%b busy=%b err=%b ready=%b, required all 0",
                 valid_o, busy_o, err_o, ready_o);
      end
      exp_q.delete();
      mdl_left = 0;
    end else begin
      m_sel = (mdl_left != 0) ? mdl_dest : sel_i;
      m_rdy = (int'(m_sel) < N) ? (exp_q.size() < 2) : ERR_EN;
      m_vld = '0;
      if (exp_q.size() > 0) m_vld[exp_q[0].sel] = 1'b1;
      checks++;
      if (ready_o !== m_rdy) begin
        failures++;
        $display("FAIL sb_ready_o got=%b want=%b t=%0t", ready_o, m_rdy, $time);
      end
      checks++;
      if (valid_o !== m_vld) begin
        failures++;
        $display("FAIL sb_valid_o got=%b want=%b t=%0t", valid_o, m_vld, $time);
      end
      checks++;
      if (busy_o !== (mdl_left != 0) || err_o !== 1'b0) begin
        failures++;
        $display("FAIL sb_busy_err busy=%b err=%b want busy=%b err=0 t=%0t",
                 busy_o, err_o, (mdl_left != 0), $time);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (data_o[exp_q[0].sel*DATA_W +: DATA_W] !== exp_q[0].data) begin
          failures++;
          $display("FAIL sb_data lane=%0d got=%h want=%h t=%0t", exp_q[0].sel,
                   data_o[exp_q[0].sel*DATA_W +: DATA_W], exp_q[0].data, $time);
        end
        if (ready_i[exp_q[0].sel]) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
      if (valid_i && m_rdy) begin
        if (mdl_left == 0) begin
          mdl_dest = sel_i;
          mdl_left = int'(beats_i);
        end else begin
          mdl_left--;
        end
        if (int'(mdl_dest) < N) exp_q.push_back('{sel: mdl_dest, data: data_i});
      end
    end
  end

  // Present one beat from posedge+1 and hold it until accepted (bounded).
  task automatic send_beat(input logic [SEL_W-1:0] s, input logic [BEAT_W-1:0] b,
                           input logic [DATA_W-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    valid_i = 1'b1; sel_i = s; beats_i = b; data_i = d;
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      n++;
      if (rand_rdy) ready_i = N'($urandom);
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout sel=%0d no accept within 64 cycles", s);
    end
  endtask

  task automatic idle_cycles(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ready_o, valid_o, busy_o, err_o} !== '0) begin
      failures++;
      $display("FAIL reset_hold ready=%b valid=%b busy=%b err=%b, required 0",
               ready_o, valid_o, busy_o, err_o);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || b_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_release ready=%b b_ready=%b, required 1 1", ready_o, b_ready_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    ready_i = '1;
    send_beat(2'd2, 4'd0, 64'hA5);
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 4'b0100 || data_o[2*DATA_W +: DATA_W] !== 64'hA5 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_beat valid=%b lane2=%h busy=%b, required 0100 a5 0",
               valid_o, data_o[2*DATA_W +: DATA_W], busy_o);
    end
    idle_cycles(2);
  endtask

  task automatic test_burst();
    int busy_cnt = 0;
    int d0;
    ready_i = '1;
    d0 = delivered;
    for (int i = 0; i < 4; i++) begin
      send_beat((i == 0) ? 2'd1 : 2'd3, (i == 0) ? 4'd3 : BEAT_W'($urandom),
                64'h1000 + 64'(i));
      if (busy_o) busy_cnt++;
    end
    valid_i = 1'b0;
    checks++;
    if (busy_cnt != 3 || busy_o !== 1'b0 || valid_o !== 4'b0010) begin
      failures++;
      $display("FAIL burst4 busy_cycles=%0d busy_end=%b valid=%b, required 3 0 0010",
               busy_cnt, busy_o, valid_o);
    end
    idle_cycles(3);
    checks++;
    if (delivered - d0 != 4) begin
      failures++;
      $display("FAIL burst4_count delivered=%0d required 4", delivered - d0);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int d0;
    d0 = delivered;
    ready_i = 4'b1110;
    valid_i = 1'b1; sel_i = 2'd0; beats_i = '0; data_i = 64'hB0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready_o) acc++;
      @(posedge clk);
      #1;
      data_i = 64'hB0 + 64'(acc);
    end
    checks++;
    if (acc != 2 || ready_o !== 1'b0 || valid_o !== 4'b0001 ||
        data_o[0 +: DATA_W] !== 64'hB0) begin
      failures++;
      $display("FAIL backpressure accepts=%0d ready=%b valid=%b lane0=%h, required 2 0 0001 b0",
               acc, ready_o, valid_o, data_o[0 +: DATA_W]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data_o[0 +: DATA_W] !== 64'hB0) begin
      failures++;
      $display("FAIL backpressure_stable lane0=%h required b0", data_o[0 +: DATA_W]);
    end
    ready_i = '1;
    send_beat(2'd0, 4'd0, 64'hB2);
    idle_cycles(4);
    checks++;
    if (delivered - d0 != 3) begin
      failures++;
      $display("FAIL backpressure_drain delivered=%0d required 3", delivered - d0);
    end
  endtask

  task automatic test_max_burst();
    int d0;
    logic busy_pre;
    ready_i = '1;
    d0 = delivered;
    busy_pre = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send_beat(SEL_W'($urandom), (i == 0) ? 4'd15 : BEAT_W'($urandom), 64'($urandom));
      if (i == 14) busy_pre = busy_o;
    end
    valid_i = 1'b0;
    checks++;
    if (busy_pre !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL max_burst_busy before_last=%b after_last=%b, required 1 0", busy_pre, busy_o);
    end
    idle_cycles(3);
    checks++;
    if (delivered - d0 != 16) begin
      failures++;
      $display("FAIL max_burst_count delivered=%0d required 16", delivered - d0);
    end
  endtask

  task automatic test_reset_mid();
    ready_i = '1;
    send_beat(2'd1, 4'd7, 64'hC0);
    send_beat(2'd1, 4'd0, 64'hC1);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (valid_o !== '0 || busy_o !== 1'b0 || ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async valid=%b busy=%b ready=%b, required 0 0 0",
               valid_o, busy_o, ready_o);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send_beat(2'd0, 4'd0, 64'h5555);
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 4'b0001 || data_o[0 +: DATA_W] !== 64'h5555 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after valid=%b lane0=%h busy=%b, required 0001 5555 0",
               valid_o, data_o[0 +: DATA_W], busy_o);
    end
    idle_cycles(3);
  endtask

  task automatic test_random();
    int sent = 0;
    int d0;
    int b;
    d0 = delivered;
    rand_rdy = 1'b1;
    for (int m = 0; m < 40; m++) begin
      b = $urandom_range(0, 3);
      for (int i = 0; i <= b; i++) begin
        send_beat((i == 0) ? SEL_W'($urandom) : SEL_W'($urandom),
                  (i == 0) ? BEAT_W'(b) : BEAT_W'($urandom), {$urandom, $urandom});
        sent++;
      end
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    ready_i = '1;
    idle_cycles(6);
    checks++;
    if (delivered - d0 != sent || valid_o !== '0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain delivered=%0d sent=%0d valid=%b pending=%0d",
               delivered - d0, sent, valid_o, exp_q.size());
    end
  endtask

  task automatic test_out_of_range();
    int acc = 0;
    int errs = 0;
    int acc_cyc = -1;
    int err_cyc = -1;
    bit vseen = 1'b0;
    b_ready = '1;
    b_valid = 1'b1; b_sel = 2'd3; b_beats = 4'd1; b_data = 64'hDD;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b_valid && b_ready_o) begin
        acc++;
        if (acc == 1) acc_cyc = c;
      end
      if (b_err_o) begin
        errs++;
        err_cyc = c;
      end
      if (b_valid_o !== '0) vseen = 1'b1;
      @(posedge clk);
      #1;
      if (acc == 2) b_valid = 1'b0;
    end
    b_valid = 1'b0;
`ifdef TL_DEMUX_ERR_SINK_EN
    checks++;
    if (acc != 2 || errs != 1 || err_cyc != acc_cyc + 1 || vseen) begin
      failures++;
      $display("FAIL oor_drop accepts=%0d errs=%0d err_cyc=%0d acc_cyc=%0d vseen=%0b, required 2 1 acc+1 0",
               acc, errs, err_cyc, acc_cyc, vseen);
    end
`else
    checks++;
    if (acc != 0 || errs != 0 || vseen || b_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL oor_stall accepts=%0d errs=%0d vseen=%0b ready=%b, required 0 0 0 0",
               acc, errs, vseen, b_ready_o);
    end
`endif
    b_sel = 2'd2;
    #1;
    checks++;
    if (b_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL oor_recover ready=%b required 1", b_ready_o);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_max_burst();
    test_reset_mid();
    test_random();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
